// File: rtl/imem_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_load_arbiter
// Description : Single-port instruction memory arbiter. Shares the memory port
//               between the fetch stage and a boot/patch loader. After reset a
//               BOOT phase (if strapped) holds the core while the loader fills
//               memory; in RUN the loader steals bounded bursts from fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_load_arbiter #(
  parameter int DEPTH     = 256,
  parameter int BURST_MAX = 4,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          boot_en,
  // loader side
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          ld_err,
  // fetch side
  input  logic [31:0]   PCF,
  input  logic          fetch_en,
  output logic [31:0]   instruction,
  output logic          stall_F,
  // core control / status
  output logic          core_hold,
  output logic          boot_done,
  output logic [AW:0]   words_loaded,
  // memory port
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  // Burst counter must be able to hold BURST_MAX itself.
  localparam int            BCW         = $clog2(BURST_MAX + 1);
  localparam logic [BCW-1:0] BURST_LIMIT = BCW'(BURST_MAX);
  localparam logic [AW:0]   WORDS_FULL  = (AW + 1)'(DEPTH);
  localparam logic [31:0]   NOP_INSTR   = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_BOOT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t          r_state;
  logic [BCW-1:0]  r_burst_cnt;

  logic            w_grant_ld;     // loader owns the port this cycle (word consumed)
  logic            w_addr_ok;      // accepted word would be a legal write
  logic            w_in_range;
  logic [AW-1:0]   w_ld_idx;
  logic [AW-1:0]   w_pc_idx;
  logic            w_fetch_served;
  logic            w_pcf_unused;

  // Address decode: word index plus alignment / range qualification.
  assign w_ld_idx     = ld_addr[AW+1:2];
  assign w_pc_idx     = PCF[AW+1:2];
  assign w_in_range   = (ld_addr[31:AW+2] == '0);
  assign w_addr_ok    = (ld_addr[1:0] == 2'b00) && w_in_range;
  // Upper and byte-offset PCF bits are deliberately ignored (address aliasing).
  assign w_pcf_unused = ^{PCF[31:AW+2], PCF[1:0]};

  // Per-state port ownership and handshake generation.
  always_comb begin
    w_grant_ld = 1'b0;
    ld_ready   = 1'b0;
    stall_F    = 1'b1;
    core_hold  = 1'b1;
    case (r_state)
      ST_INIT: begin
        w_grant_ld = 1'b0;
        ld_ready   = 1'b0;
      end
      ST_BOOT: begin
        // The loader is always welcome during BOOT; fetch is frozen.
        ld_ready   = 1'b1;
        w_grant_ld = ld_valid;
      end
      ST_RUN: begin
        // Collisions favour the loader until the burst budget is spent.
        w_grant_ld = ld_valid & (~fetch_en | (r_burst_cnt < BURST_LIMIT));
        ld_ready   = w_grant_ld;
        stall_F    = fetch_en & w_grant_ld;
        core_hold  = 1'b0;
      end
      default: begin
        w_grant_ld = 1'b0;
        ld_ready   = 1'b0;
      end
    endcase
  end

  assign w_fetch_served = (r_state == ST_RUN) && fetch_en && !w_grant_ld;

  // Memory port mux: loader index when granted, otherwise fetch address.
  always_comb begin
    mem_addr  = w_grant_ld ? w_ld_idx : w_pc_idx;
    mem_we    = w_grant_ld & w_addr_ok;
    mem_wdata = mem_we ? ld_data : 32'h0;
  end

  // Decode sees real memory data only when fetch actually owns the port.
  always_comb begin
    instruction = w_fetch_served ? mem_rdata : NOP_INSTR;
  end

  // Phase sequencing: INIT is a single cycle, BOOT ends after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      boot_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (boot_en) begin
            r_state <= ST_BOOT;
          end else begin
            r_state   <= ST_RUN;
            boot_done <= 1'b1;
          end
        end
        ST_BOOT: begin
          // A bad word flagged as last still terminates BOOT.
          if (w_grant_ld && ld_last) begin
            r_state   <= ST_RUN;
            boot_done <= 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Consecutive loader grants against a waiting fetch; any idle cycle resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= '0;
    end else if (r_state != ST_RUN || !w_grant_ld) begin
      r_burst_cnt <= '0;
    end else if (fetch_en) begin
      r_burst_cnt <= r_burst_cnt + 1'b1;
    end
  end

  // One-cycle error pulse for a consumed word that could not be written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_err <= 1'b0;
    end else begin
      ld_err <= w_grant_ld & ~w_addr_ok;
    end
  end

  // Count of successful writes, saturating at the memory depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_loaded <= '0;
    end else if (mem_we && (words_loaded != WORDS_FULL)) begin
      words_loaded <= words_loaded + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_load_arbiter
// Description : Self-checking bench for imem_load_arbiter. Drives directed and
//               random loader/fetch traffic and compares every cycle against a
//               phase-level behavioural model with a shadow memory image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_load_arbiter;

  localparam int          DEPTH     = 256;
  localparam int          BURST_MAX = 4;
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic          clk;
  logic          rst_n;
  logic          boot_en;
  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_err;
  logic [31:0]   PCF;
  logic          fetch_en;
  logic [31:0]   instruction;
  logic          stall_F;
  logic          core_hold;
  logic          boot_done;
  logic [AW:0]   words_loaded;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  // Harness memory the DUT drives, and the model's independent image of it.
  logic [31:0] tb_mem  [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: 0 = INIT, 1 = BOOT, 2 = RUN.
  int m_phase;
  int m_streak;
  bit m_err;
  bit m_done;
  int m_loaded;

  logic        last_ready;
  logic [31:0] last_instr;

  imem_load_arbiter #(
    .DEPTH     (DEPTH),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .boot_en      (boot_en),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .ld_err       (ld_err),
    .PCF          (PCF),
    .fetch_en     (fetch_en),
    .instruction  (instruction),
    .stall_F      (stall_F),
    .core_hold    (core_hold),
    .boot_done    (boot_done),
    .words_loaded (words_loaded),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
  endtask

  // Asynchronous reset in the middle of whatever is going on; released next negedge.
  task automatic do_reset(input bit be);
    rst_n    = 1'b0;
    boot_en  = be;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    fetch_en = 1'b0;
    #1;
    m_phase  = 0;
    m_streak = 0;
    m_err    = 1'b0;
    m_done   = 1'b0;
    m_loaded = 0;
    check_val("rst_boot_done", 32'(boot_done), 32'd0);
    check_val("rst_words",     32'(words_loaded), 32'd0);
    check_val("rst_ld_err",    32'(ld_err), 32'd0);
    check_val("rst_core_hold", 32'(core_hold), 32'd1);
    check_val("rst_ld_ready",  32'(ld_ready), 32'd0);
    check_val("rst_instr",     instruction, NOP_INSTR);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive, check against model, advance the model at the edge.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                      input bit last, input bit fe, input logic [31:0] pc);
    bit          acc, good, we, served;
    int          idx, pidx;
    logic [31:0] exp_instr;
    ld_valid = v;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    fetch_en = fe;
    PCF      = pc;
    #1;
    good = (a % 4 == 0) && (a < 32'(DEPTH * 4));
    idx  = int'((a / 4) % DEPTH);
    pidx = int'((pc / 4) % DEPTH);
    if (m_phase == 1)      acc = v;
    else if (m_phase == 2) acc = v && (!fe || m_streak < BURST_MAX);
    else                   acc = 1'b0;
    we        = acc && good;
    served    = (m_phase == 2) && fe && !acc;
    exp_instr = served ? ref_mem[pidx] : NOP_INSTR;

    check_val("ld_ready",     32'(ld_ready),  32'((m_phase == 1) || acc));
    check_val("stall_F",      32'(stall_F),   32'((m_phase != 2) || (fe && acc)));
    check_val("core_hold",    32'(core_hold), 32'(m_phase != 2));
    check_val("boot_done",    32'(boot_done), 32'(m_done));
    check_val("words_loaded", 32'(words_loaded), 32'(m_loaded));
    check_val("ld_err",       32'(ld_err),    32'(m_err));
    check_val("mem_we",       32'(mem_we),    32'(we));
    check_val("instruction",  instruction,    exp_instr);
    if (acc)    check_val("mem_addr_ld", 32'(mem_addr), 32'(idx));
    if (we)     check_val("mem_wdata",   mem_wdata, d);
    if (served) check_val("mem_addr_pc", 32'(mem_addr), 32'(pidx));
    last_ready = ld_ready;
    last_instr = instruction;

    @(posedge clk);
    m_err = acc && !good;
    if (we) begin
      ref_mem[idx] = d;
      if (m_loaded < DEPTH) m_loaded++;
    end
    if (m_phase == 2) begin
      if (!acc)    m_streak = 0;
      else if (fe) m_streak++;
    end else begin
      m_streak = 0;
    end
    if (m_phase == 0) begin
      if (boot_en) m_phase = 1;
      else begin m_phase = 2; m_done = 1'b1; end
    end else if (m_phase == 1 && acc && last) begin
      m_phase = 2;
      m_done  = 1'b1;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
    if (r == 1) return ($urandom_range(0, DEPTH - 1) * 4) | (32'd1 << $urandom_range(AW + 2, 31));
    return $urandom_range(0, DEPTH - 1) * 4;
  endfunction

  initial begin
    logic [6:0]  pattern;
    logic [31:0] addr;
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = 32'hA500_0000 + 32'(i);
      ref_mem[i] = 32'hA500_0000 + 32'(i);
    end
    rst_n = 1'b1; boot_en = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    ld_last = 1'b0; fetch_en = 1'b0; PCF = '0; last_ready = 1'b0; last_instr = '0;
    @(negedge clk);

    // Reset into BOOT: one INIT cycle, then a held core.
    do_reset(1'b1);
    step(0, 32'h0, 32'h0, 0, 1, 32'h0);
    step(0, 32'h0, 32'h0, 0, 1, 32'h4);
    check_val("t1_boot_hold", 32'(core_hold), 32'd1);

    // Boot load with two bad words interleaved; 0x8 is the last word.
    step(1, 32'h0,   32'hAAAA_0001, 0, 0, 32'h0);
    step(1, 32'h4,   32'hBBBB_0002, 0, 0, 32'h0);
    step(1, 32'h402, 32'hDEAD_0003, 0, 0, 32'h0);
    check_val("t3_err_mis", 32'(ld_err), 32'd1);
    step(1, 32'h400, 32'hDEAD_0004, 0, 0, 32'h0);
    check_val("t3_err_oor", 32'(ld_err), 32'd1);
    step(1, 32'h8,   32'hCCCC_0005, 1, 0, 32'h0);
    check_val("t3_err_clr", 32'(ld_err), 32'd0);
    check_val("t2_loaded",  32'(words_loaded), 32'd3);
    check_val("t2_done",    32'(boot_done), 32'd1);
    step(0, 32'h0, 32'h0, 0, 1, 32'h8);
    check_val("t2_fetch_c", last_instr, 32'hCCCC_0005);

    // Burst limit: loader 4, fetch 1, loader 2.
    pattern = '0;
    addr    = 32'h20;
    for (int i = 0; i < 7; i++) begin
      step(1, addr, 32'h5500_0000 + addr, 0, 1, 32'h4);
      pattern = {pattern[5:0], last_ready};
      if (last_ready) addr = addr + 4;
    end
    check_val("t4_burst", 32'(pattern), 32'(7'b1111011));

    // Patch then fetch, including an aliased PC.
    step(1, 32'h10, 32'hD00D_F00D, 0, 0, 32'h0);
    step(0, 32'h0, 32'h0, 0, 1, 32'h10);
    check_val("t5_fetch", last_instr, 32'hD00D_F00D);
    step(0, 32'h0, 32'h0, 0, 1, 32'h410);
    check_val("t5_alias", last_instr, 32'hD00D_F00D);

    // Saturation of the write counter.
    for (int i = 0; i < DEPTH + 4; i++)
      step(1, 32'((i % DEPTH) * 4), $urandom, 0, 0, 32'h0);
    check_val("sat_words", 32'(words_loaded), 32'(DEPTH));

    // Random episodes across all phases.
    for (int e = 0; e < 4; e++) begin
      do_reset(1'($urandom_range(0, 1)));
      for (int i = 0; i < 120; i++)
        step(1'($urandom_range(0, 1)), rand_addr(), $urandom,
             ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset mid-BOOT, then straight to RUN; memory keeps the partial load.
    do_reset(1'b1);
    step(0, 32'h0, 32'h0, 0, 0, 32'h0);
    step(1, 32'h0, 32'hEEEE_0000, 0, 0, 32'h0);
    step(1, 32'h4, 32'hFFFF_0001, 0, 0, 32'h0);
    do_reset(1'b0);
    step(0, 32'h0, 32'h0, 0, 0, 32'h0);
    check_val("t6_done",  32'(boot_done), 32'd1);
    check_val("t6_words", 32'(words_loaded), 32'd0);
    check_val("t6_mem0",  tb_mem[0], 32'hEEEE_0000);
    check_val("t6_mem1",  tb_mem[1], 32'hFFFF_0001);
    step(0, 32'h0, 32'h0, 0, 1, 32'h4);
    check_val("t6_fetch", last_instr, 32'hFFFF_0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
